// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   Serial UART transmitter. Takes bytes from an upstream req/data source and
//   shifts them out as start bit (0), data bits LSB first, optional even
//   parity, then 1 + extra_stop_bits stop bits (1). The line idles high.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     When defined, an even-parity bit (XOR of the data byte) is sent after
//     data bit 7 and before the stop bits.
//
// Parameters
//   cycles_per_bit  : clk cycles each serial bit is held (>= 2)
//   extra_stop_bits : stop bits beyond the mandatory one (>= 0)
//
// Ports
//   clk      : clock
//   rst_n    : asynchronous active-low reset; aborts any frame in flight
//   i_data   : byte to send, sampled only on the accept edge
//   i_req    : upstream has a valid byte
//   o_serial : registered UART line, idle high
//   o_cts    : clear-to-send (combinational); accept = i_req && o_cts
//   o_idle   : no frame in flight (combinational, state == IDLE)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned cycles_per_bit  = 4,
    parameter int unsigned extra_stop_bits = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_req,
    output logic       o_serial,
    output logic       o_cts,
    output logic       o_idle
);

`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    localparam int unsigned NBITS = 10 + extra_stop_bits + PAR_BITS;
    localparam int unsigned CNT_W = $clog2(cycles_per_bit);
    localparam int unsigned BIT_W = $clog2(NBITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cycles_per_bit - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
    // Cursor position of data bit 7 (cursor 0 is the start bit).
    localparam logic [BIT_W-1:0] BIT_D7   = BIT_W'(8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              serial_q, serial_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic bit_end_c;
    logic final_c;
    logic cts_c;
    logic accept_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            serial_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state, counters, shift register and next line value.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        bit_end_c = (cnt_q == CNT_LAST);
        // Last cycle of the last stop bit: the only in-frame accept slot.
        final_c   = (state_q == ST_STOP) && (bit_q == BIT_LAST) && bit_end_c;
        cts_c     = (state_q == ST_IDLE) || final_c;
        accept_c  = i_req && cts_c;

        if (accept_c) begin
            state_d = ST_START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = i_data;
`ifdef UART_TX_PARITY_EN
            parity_d = ^i_data;
`endif
        end else if (state_q != ST_IDLE) begin
            if (bit_end_c) begin
                cnt_d = '0;
                bit_d = bit_q + BIT_W'(1);
                unique case (state_q)
                    ST_START: state_d = ST_DATA;
                    ST_DATA: begin
                        // Next data bit always sits in shift_q[0].
                        shift_d = {1'b1, shift_q[7:1]};
                        if (bit_q == BIT_D7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: state_d = ST_STOP;
`endif
                    ST_STOP: begin
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_IDLE;
                            bit_d   = '0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Register the value of the bit that will be on the line next cycle.
        unique case (state_d)
            ST_IDLE:   serial_d = 1'b1;
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_d = parity_d;
`endif
            ST_STOP:   serial_d = 1'b1;
            default:   serial_d = 1'b1;
        endcase
    end

    assign o_serial = serial_q;
    assign o_cts    = cts_c;
    assign o_idle   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Directed self-checking bench for uart_tx with default parameters
//   (cycles_per_bit = 4, extra_stop_bits = 1). Inputs change 1 time unit
//   after the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 12;
`else
    localparam int NB  = 11;
`endif
    localparam int FR  = NB * CPB;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_data;
    logic       i_req;
    logic       o_serial;
    logic       o_cts;
    logic       o_idle;

    int checks;
    int failures;

    uart_tx #(
        .cycles_per_bit (CPB),
        .extra_stop_bits(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .i_req   (i_req),
        .o_serial(o_serial),
        .o_cts   (o_cts),
        .o_idle  (o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for frame bit k of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        i_req  = 1'b0;
        i_data = 8'h00;
        repeat (5) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({o_serial, o_cts, o_idle} !== 3'b111) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got ser/cts/idle=%b%b%b want 111",
                         c, o_serial, o_cts, o_idle);
            end
            tick();
        end
    endtask

    // Pulse one request from idle and check every cycle of the frame.
    task automatic test_single_byte(input logic [7:0] b);
        checks++;
        if (o_cts !== 1'b1) begin
            failures++;
            $display("FAIL single_cts_pre byte=%h got %b want 1", b, o_cts);
        end
        i_data = b;
        i_req  = 1'b1;
        tick();
        i_req  = 1'b0;
        i_data = ~b;
        for (int c = 0; c < FR; c++) begin
            checks++;
            if (o_serial !== exp_bit(b, c / CPB) || o_cts !== (c == FR - 1) || o_idle !== 1'b0) begin
                failures++;
                $display("FAIL single_frame byte=%h cyc=%0d got ser/cts/idle=%b%b%b want %b%b0",
                         b, c, o_serial, o_cts, o_idle, exp_bit(b, c / CPB), (c == FR - 1));
            end
            tick();
        end
        checks++;
        if (o_idle !== 1'b1 || o_serial !== 1'b1 || o_cts !== 1'b1) begin
            failures++;
            $display("FAIL single_end byte=%h got ser/cts/idle=%b%b%b want 111",
                     b, o_serial, o_cts, o_idle);
        end
    endtask

    task automatic test_back_to_back();
        i_data = 8'h00;
        i_req  = 1'b1;
        tick();
        i_data = 8'hFF;
        for (int c = 0; c < 2 * FR; c++) begin
            logic [7:0] b;
            int         p;
            b = (c < FR) ? 8'h00 : 8'hFF;
            p = c % FR;
            if (c == FR) i_req = 1'b0;
            checks++;
            if (o_serial !== exp_bit(b, p / CPB) || o_cts !== (p == FR - 1) || o_idle !== 1'b0) begin
                failures++;
                $display("FAIL b2b_frame cyc=%0d got ser/cts/idle=%b%b%b want %b%b0",
                         c, o_serial, o_cts, o_idle, exp_bit(b, p / CPB), (p == FR - 1));
            end
            tick();
        end
        checks++;
        if (o_idle !== 1'b1 || o_serial !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end got ser/idle=%b%b want 11", o_serial, o_idle);
        end
    endtask

    task automatic test_ignored_req();
        i_data = 8'hA3;
        i_req  = 1'b1;
        tick();
        i_req = 1'b0;
        for (int c = 0; c < FR; c++) begin
            if (c == 8) begin
                i_req  = 1'b1;
                i_data = 8'h11;
            end
            if (c == 36) i_req = 1'b0;
            checks++;
            if (o_serial !== exp_bit(8'hA3, c / CPB) || o_cts !== (c == FR - 1)) begin
                failures++;
                $display("FAIL ignore_frame cyc=%0d got ser/cts=%b%b want %b%b",
                         c, o_serial, o_cts, exp_bit(8'hA3, c / CPB), (c == FR - 1));
            end
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (o_idle !== 1'b1 || o_serial !== 1'b1) begin
                failures++;
                $display("FAIL ignore_no_second cyc=%0d got ser/idle=%b%b want 11",
                         c, o_serial, o_idle);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        i_data = 8'h0F;
        i_req  = 1'b1;
        tick();
        i_req = 1'b0;
        // Data bit 4 of 0x0F (a 0) occupies frame cycles 20..23.
        repeat (21) tick();
        checks++;
        if (o_serial !== 1'b0 || o_idle !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pre got ser/idle=%b%b want 00", o_serial, o_idle);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_serial !== 1'b1 || o_idle !== 1'b1 || o_cts !== 1'b1) begin
            failures++;
            $display("FAIL midrst_abort got ser/cts/idle=%b%b%b want 111",
                     o_serial, o_cts, o_idle);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_single_byte(8'h80);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        test_single_byte(8'h07);
        test_single_byte(8'h03);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_byte(8'h55);
        repeat (3) tick();
        test_back_to_back();
        repeat (2) tick();
        test_ignored_req();
        test_reset_mid_frame();
        test_single_byte(8'hC6);
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
